// File: rtl/fifo_wr_arbiter.sv
// Round-robin write-port arbiter for the async FIFO. It grants one requester at a time
// for bursts of up to MAX_BURST words, and fifo_full stalls the burst without ending it.
module fifo_wr_arbiter #(
  parameter  int N_REQ     = 4,
  parameter  int DATA_W    = 8,
  parameter  int MAX_BURST = 4,
  localparam int OWN_W     = $clog2(N_REQ),
  localparam int CNT_W     = $clog2(MAX_BURST + 1)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [N_REQ-1:0]        req,
  input  logic [N_REQ*DATA_W-1:0] req_data,
  input  logic                    fifo_full,
  output logic [N_REQ-1:0]        gnt,
  output logic [OWN_W-1:0]        owner,
  output logic                    busy,
  output logic                    w_en,
  output logic [DATA_W-1:0]       data_in
);

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_GRANT = 1'b1;

  logic [0:0]       state_q, state_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic [OWN_W-1:0] owner_q, owner_d;
  logic [OWN_W-1:0] rr_ptr_q, rr_ptr_d;
  logic             busy_q, busy_d;
  logic [CNT_W-1:0] burst_q, burst_d;

  logic [OWN_W-1:0] pick;
  logic             pick_vld;
  logic             burst_last;

  // Search from rr_ptr upwards with wrap; descending loop lets the closest hit win.
  always_comb begin
    pick     = rr_ptr_q;
    pick_vld = 1'b0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      int unsigned      idx;
      logic [OWN_W-1:0] idx_w;
      idx   = (int'(rr_ptr_q) + i) % N_REQ;
      idx_w = OWN_W'(idx);
      if (req[idx_w]) begin
        pick     = idx_w;
        pick_vld = 1'b1;
      end
    end
  end

  assign w_en       = busy_q & req[owner_q] & ~fifo_full;
  assign data_in    = req_data[owner_q*DATA_W +: DATA_W];
  assign burst_last = (burst_q == CNT_W'(MAX_BURST - 1));

  always_comb begin
    // NOTE: every next-state signal gets a hold default first so no path infers a latch.
    state_d  = state_q;
    gnt_d    = gnt_q;
    owner_d  = owner_q;
    rr_ptr_d = rr_ptr_q;
    busy_d   = busy_q;
    burst_d  = burst_q;
    case (state_q)
      S_IDLE: begin
        if (pick_vld) begin
          owner_d     = pick;
          gnt_d       = '0;
          gnt_d[pick] = 1'b1;
          busy_d      = 1'b1;
          burst_d     = '0;
          state_d     = S_GRANT;
        end
      end
      S_GRANT: begin
        if (w_en) begin
          burst_d = burst_q + 1'b1;
        end
        if (!req[owner_q] || (w_en && burst_last)) begin
          gnt_d    = '0;
          busy_d   = 1'b0;
          rr_ptr_d = (owner_q == OWN_W'(N_REQ - 1)) ? '0 : owner_q + 1'b1;
          state_d  = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      gnt_q    <= '0;
      owner_q  <= '0;
      rr_ptr_q <= '0;
      busy_q   <= 1'b0;
      burst_q  <= '0;
    end else begin
      state_q  <= state_d;
      gnt_q    <= gnt_d;
      owner_q  <= owner_d;
      rr_ptr_q <= rr_ptr_d;
      busy_q   <= busy_d;
      burst_q  <= burst_d;
    end
  end

  assign gnt   = gnt_q;
  assign owner = owner_q;
  assign busy  = busy_q;

endmodule
